// File: rtl/wa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wa_pkg
// Brief    : Shared types and helpers for the multi-lane workload analyzer.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
package wa_pkg;

    // Request FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } wa_state_e;

    // Unsigned add clamped to 2^w-1; the carry bit guarantees no wrap
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        sat_add = (s > lim) ? lim[31:0] : s[31:0];
    endfunction

    // Number of set bits in a lane mask
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + int'(v[i]);
        end
        popcount = cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wa_if.sv
`default_nettype none
// ============================================================================
// Module   : wa_if
// Brief    : Retire telemetry, lookahead occupancy and arbiter handshake bus.
//            master = retire stage / arbiter side, slave = analyzer.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
interface wa_if #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned LA_W = 4,
    parameter int unsigned CW   = 8
);
    logic            flush;
    logic [NCH-1:0]  retire_vld;
    logic [NCH-1:0]  retire_arith;
    logic [LA_W-1:0] la_count;
    logic            wa_ack;
    logic            wa_req;
    logic [CW-1:0]   confidence;
    logic [CW-1:0]   predicted_runlen;

    modport master (
        output flush, retire_vld, retire_arith, la_count, wa_ack,
        input  wa_req, confidence, predicted_runlen
    );

    modport slave (
        input  flush, retire_vld, retire_arith, la_count, wa_ack,
        output wa_req, confidence, predicted_runlen
    );
endinterface
`default_nettype wire

// File: rtl/wa_window.sv
`default_nettype none
// ============================================================================
// Module   : wa_window
// Brief    : WIN-deep circular buffer of per-cycle arithmetic counts with an
//            exact running sum and a flag set once WIN entries were written.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module wa_window #(
    parameter int unsigned WIN = 16,
    parameter int unsigned EW  = 2
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        clr,
    input  wire logic [EW-1:0]               in,
    output logic      [EW+$clog2(WIN)-1:0]   sum,
    output logic                             full
);
    localparam int unsigned SW = EW + $clog2(WIN);
    localparam int unsigned PW = $clog2(WIN);

    logic [EW-1:0] ring [WIN];
    logic [PW-1:0] wr_ptr;

    // Write one entry per cycle; the evicted entry leaves the sum as the new one enters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            sum    <= '0;
            full   <= 1'b0;
            for (int i = 0; i < int'(WIN); i++) ring[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            sum    <= '0;
            full   <= 1'b0;
            for (int i = 0; i < int'(WIN); i++) ring[i] <= '0;
        end else begin
            ring[wr_ptr] <= in;
            sum          <= sum + SW'(in) - SW'(ring[wr_ptr]);
            wr_ptr       <= wr_ptr + PW'(1);
            if (wr_ptr == PW'(WIN - 1)) full <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/workload_analyzer_mc.sv
`default_nettype none
// ============================================================================
// Module   : workload_analyzer_mc
// Brief    : Multi-lane arithmetic-intensity analyzer. Fuses a sliding-window
//            sum, an EMA and a trend counter into a confidence value and
//            raises a req/ack mode request with post-grant cooldown.
//            Optional macro WA_HYSTERESIS_EN: withdraw a pending request
//            when confidence drops below THR_LO.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module workload_analyzer_mc
    import wa_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned WIN       = 16,
    parameter int unsigned EMA_SHIFT = 2,
    parameter int unsigned CW        = 8,
    parameter int unsigned LA_W      = 4,
    parameter int unsigned THR_HI    = 20,
    parameter int unsigned THR_LO    = 12,
    parameter int unsigned MIN_HOLD  = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    wa_if.slave       bus
);
    localparam int unsigned EW  = $clog2(NCH + 1);
    localparam int unsigned SW  = EW + $clog2(WIN);
    localparam int unsigned EXW = CW + 2;
    localparam int unsigned HW  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
`ifdef WA_HYSTERESIS_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    logic [EW-1:0]  a_cnt;
    logic [EW-1:0]  n_cnt;
    logic [SW-1:0]  win_sum;
    logic           win_full;
    logic [CW-1:0]  ema, ema_nxt;
    logic [CW-1:0]  trend, trend_nxt;
    logic [CW-1:0]  conf, conf_nxt;
    logic [CW-1:0]  pred, pred_nxt;
    logic [EXW-1:0] ema_wide;
    wa_state_e      state, state_nxt;
    logic [HW-1:0]  hold_cnt, hold_nxt;

    assign a_cnt = EW'(popcount(32'(bus.retire_vld & bus.retire_arith)));
    assign n_cnt = EW'(popcount(32'(bus.retire_vld)));

    wa_window #(.WIN(WIN), .EW(EW)) u_window (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.flush),
        .in   (a_cnt),
        .sum  (win_sum),
        .full (win_full)
    );

    // Next values of EMA, trend and the two registered estimates
    always_comb begin
        ema_wide = {2'b00, ema} - EXW'(ema >> EMA_SHIFT) + (EXW'(a_cnt) << EMA_SHIFT);
        ema_nxt  = (ema_wide > {2'b00, {CW{1'b1}}}) ? {CW{1'b1}} : ema_wide[CW-1:0];

        trend_nxt = trend;
        if (n_cnt != '0) begin
            if (a_cnt != '0)       trend_nxt = CW'(sat_add(32'(trend), 32'(a_cnt), CW));
            else if (trend != '0)  trend_nxt = trend - CW'(1);
        end

        conf_nxt = CW'(sat_add(sat_add(32'(win_sum), 32'(ema >> 2), CW), 32'(trend), CW));
        pred_nxt = CW'(sat_add(32'(bus.la_count) << 1, 32'(trend >> 1), CW));
    end

    // Estimator state and output registers; flush wipes all history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ema   <= '0;
            trend <= '0;
            conf  <= '0;
            pred  <= '0;
        end else if (bus.flush) begin
            ema   <= '0;
            trend <= '0;
            conf  <= '0;
            pred  <= '0;
        end else begin
            ema   <= ema_nxt;
            trend <= trend_nxt;
            conf  <= conf_nxt;
            pred  <= pred_nxt;
        end
    end

    // Request FSM next-state logic; ack only matters while requesting
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (win_full && (32'(conf) > THR_HI)) state_nxt = REQ;
            end
            REQ: begin
                if (bus.wa_ack) begin
                    state_nxt = HOLD;
                    hold_nxt  = HW'(MIN_HOLD - 1);
                end else if (HYST_EN && (32'(conf) < THR_LO)) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
                else                hold_nxt  = hold_cnt - HW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register; flush forces IDLE from any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else if (bus.flush) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign bus.wa_req           = (state == REQ);
    assign bus.confidence       = conf;
    assign bus.predicted_runlen = pred;
endmodule
`default_nettype wire

// File: tb/tb_workload_analyzer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_workload_analyzer_mc
// Brief    : Directed scoreboard bench for workload_analyzer_mc. Stimulus
//            posts hand-computed expectations tagged with the clock edge
//            they apply to; a monitor compares them on the falling edge.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module tb_workload_analyzer_mc;
    localparam int K_CONF = 0;
    localparam int K_PRED = 1;
    localparam int K_REQ  = 2;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    wa_if #(.NCH(2), .LA_W(4), .CW(8)) bus ();

    workload_analyzer_mc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k the value is k
    always @(posedge clk) cyc <= cyc + 1;

    // Insert an expectation keeping the queue ordered by target edge
    task automatic exp_at(input int c, input int kind, input int val, input string name);
        exp_t e;
        int   i;
        e.cyc = c; e.kind = kind; e.val = val; e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] ar, input logic [3:0] la,
                         input logic ack, input logic fl);
        bus.retire_vld   = v;
        bus.retire_arith = ar;
        bus.la_count     = la;
        bus.wa_ack       = ack;
        bus.flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop every expectation due on this edge and compare
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_CONF:  act = int'(bus.confidence);
                K_PRED:  act = int'(bus.predicted_runlen);
                default: act = int'(bus.wa_req);
            endcase
            checks++;
            if (e.cyc != cyc || act != e.val) begin
                errors++;
                $display("FAIL %s at edge %0d (due %0d): got %0d expected %0d",
                         e.name, cyc, e.cyc, act, e.val);
            end
        end
    end

    initial begin
        int e0, f, g, h;
        rst = 1'b1;
        drive(2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        tick(); tick();
        exp_at(cyc, K_CONF, 0, "rst_conf");
        exp_at(cyc, K_PRED, 0, "rst_pred");
        exp_at(cyc, K_REQ,  0, "rst_req");
        tick();

        // Warm-up: both lanes arithmetic every cycle
        rst = 1'b0;
        e0  = cyc;
        drive(2'b11, 2'b11, 4'd0, 1'b0, 1'b0);
        exp_at(e0+1, K_CONF, 0,  "warm_conf1");
        exp_at(e0+2, K_CONF, 6,  "warm_conf2");
        exp_at(e0+3, K_CONF, 11, "warm_conf3");
        exp_at(e0+4, K_CONF, 16, "warm_conf4");
        exp_at(e0+5, K_CONF, 21, "warm_conf5");
        exp_at(e0+6, K_CONF, 26, "warm_conf6");
        exp_at(e0+6, K_PRED, 5,  "warm_pred6");
        exp_at(e0+15, K_REQ, 0,  "warm_req15");
        exp_at(e0+16, K_REQ, 0,  "warm_req16");
        exp_at(e0+17, K_REQ, 1,  "warm_req17");
        repeat (17) tick();

        // Handshake: one-cycle ack, then a stray ack during cooldown
        drive(2'b11, 2'b11, 4'd0, 1'b1, 1'b0);
        tick();
        drive(2'b11, 2'b11, 4'd0, 1'b0, 1'b0);
        for (int k = 18; k <= 26; k++) exp_at(e0+k, K_REQ, 0, "hold_req");
        exp_at(e0+27, K_REQ, 1, "rearm_req");
        tick(); tick();
        drive(2'b11, 2'b11, 4'd0, 1'b1, 1'b0);
        tick();
        drive(2'b11, 2'b11, 4'd0, 1'b0, 1'b0);
        repeat (6) tick();

        // Flush while requesting, alongside a two-lane arithmetic retire
        f = cyc + 1;
        drive(2'b11, 2'b11, 4'd0, 1'b0, 1'b1);
        exp_at(f,   K_CONF, 0, "flush_conf");
        exp_at(f,   K_PRED, 0, "flush_pred");
        exp_at(f,   K_REQ,  0, "flush_req");
        exp_at(f+1, K_CONF, 0, "flush_conf1");
        exp_at(f+2, K_CONF, 6, "flush_conf2");
        tick();

        // Window drop-out: 16 cycles of a=2, then retire with no arithmetic
        drive(2'b11, 2'b11, 4'd0, 1'b0, 1'b0);
        exp_at(f+16, K_REQ,  0,  "drop_req16");
        exp_at(f+17, K_REQ,  1,  "drop_req17");
        exp_at(f+17, K_CONF, 72, "drop_conf17");
        exp_at(f+18, K_CONF, 67, "drop_conf18");
        exp_at(f+18, K_PRED, 15, "drop_pred18");
        exp_at(f+19, K_CONF, 62, "drop_conf19");
        exp_at(f+20, K_CONF, 58, "drop_conf20");
        exp_at(f+32, K_CONF, 19, "drop_conf32");
        exp_at(f+33, K_CONF, 16, "drop_conf33");
        exp_at(f+33, K_PRED, 8,  "drop_pred33");
        exp_at(f+34, K_CONF, 15, "drop_conf34");
        exp_at(f+38, K_REQ,  1,  "hyst_req38");
`ifdef WA_HYSTERESIS_EN
        exp_at(f+39, K_REQ,  0,  "hyst_req39");
        exp_at(f+40, K_REQ,  0,  "hyst_req40");
`else
        exp_at(f+39, K_REQ,  1,  "hyst_req39");
        exp_at(f+40, K_REQ,  1,  "hyst_req40");
`endif
        repeat (16) tick();
        drive(2'b11, 2'b00, 4'd0, 1'b0, 1'b0);
        repeat (24) tick();

        // Saturation: flush, two cycles of arith without valid, then 300 all-arith cycles
        g = cyc + 1;
        drive(2'b00, 2'b11, 4'd15, 1'b0, 1'b1);
        exp_at(g,   K_CONF, 0,  "sat_flush_conf");
        exp_at(g,   K_REQ,  0,  "sat_flush_req");
        exp_at(g+1, K_PRED, 30, "novld_pred1");
        exp_at(g+3, K_CONF, 0,  "novld_conf3");
        exp_at(g+3, K_PRED, 30, "novld_pred3");
        tick();
        drive(2'b00, 2'b11, 4'd15, 1'b0, 1'b0);
        tick(); tick();
        h = cyc;
        drive(2'b11, 2'b11, 4'd15, 1'b0, 1'b0);
        exp_at(h+10,  K_CONF, 43,  "sat_conf10");
        exp_at(h+10,  K_PRED, 39,  "sat_pred10");
        exp_at(h+127, K_PRED, 156, "sat_pred127");
        exp_at(h+128, K_PRED, 157, "sat_pred128");
        exp_at(h+300, K_CONF, 255, "sat_conf300");
        exp_at(h+300, K_PRED, 157, "sat_pred300");
        repeat (300) tick();

        // Drain remaining expectations with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog in case the run stalls
    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL watchdog: got timeout expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end
endmodule
`default_nettype wire
